dct_frame_buffer: RTL

Ping-pong input framer that sits directly upstream of the 4-point `DCT` block. It accepts a serial stream of signed 8-bit samples under a valid/ready handshake. It packs each run of four consecutive samples into one block and presents that block as a 4-element array on `blk_dt_o`, which drives the DCT's `dt_i`. Two banks allow one block to be filled while the other is held for the DCT consumer, so the framer sustains one sample per cycle.

---
 rtl/dct_frame_buffer.sv | 83 ++++++++
 1 files changed

// File: rtl/dct_frame_buffer.sv
// rtl/dct_frame_buffer.sv - ping-pong 4-sample framer feeding the 4-point DCT
// Optional: DCT_FRAME_LVL_SHIFT_EN stores unsigned pixels as signed (MSB inverted).
module dct_frame_buffer #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [DW-1:0] s_dt_i,
  input  logic          s_vld_i,
  output logic          s_rdy_o,
  output logic [DW-1:0] blk_dt_o [0:3],
  output logic          blk_vld_o,
  input  logic          blk_rdy_i,
  output logic [1:0]    blk_cnt_o
);

  logic [DW-1:0] bank [0:1][0:3];
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          wr_bank;
  logic [1:0]    wr_idx;
  logic          rd_bank;
  logic          in_hs;
  logic          out_hs;
  logic [DW-1:0] wr_data;

`ifdef DCT_FRAME_LVL_SHIFT_EN
  // Subtracting 2^(DW-1) from an unsigned pixel is just an MSB flip.
  assign wr_data = {~s_dt_i[DW-1], s_dt_i[DW-2:0]};
`else
  assign wr_data = s_dt_i;
`endif

  assign s_rdy_o   = !full[wr_bank];
  assign blk_vld_o = full[rd_bank];
  assign blk_cnt_o = {1'b0, full[0]} + {1'b0, full[1]};
  assign in_hs     = s_vld_i && s_rdy_o;
  assign out_hs    = blk_vld_o && blk_rdy_i;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      blk_dt_o[i] = bank[rd_bank][i];
    end
  end

  // A completing write and a read on the same edge always hit different banks.
  always_comb begin
    full_nxt = full;
    if (in_hs && (wr_idx == 2'd3)) begin
      full_nxt[wr_bank] = 1'b1;
    end
    if (out_hs) begin
      full_nxt[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 4; i++) begin
          bank[b][i] <= '0;
        end
      end
      full    <= '0;
      wr_bank <= 1'b0;
      wr_idx  <= 2'd0;
      rd_bank <= 1'b0;
    end else begin
      if (in_hs) begin
        bank[wr_bank][wr_idx] <= wr_data;
        wr_idx                <= wr_idx + 2'd1;
        if (wr_idx == 2'd3) begin
          wr_bank <= ~wr_bank;
        end
      end
      if (out_hs) begin
        rd_bank <= ~rd_bank;
      end
      full <= full_nxt;
    end
  end

endmodule
